regfile_port_arbiter: RTL

Shares the two ports of the 16×16-bit register file among `NREQ` requesters: fetch/decode operand reads, ALU writeback, load/store writeback and debug. Each cycle it grants at most two requests, round-robin and fair, and drives them onto port 1 and port 2. It keeps the register file's rule that a port never reads and writes in the same cycle. Read data is registered and returned to the owning requester one cycle after grant.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_port_arbiter_if.sv | 51 +++++
 rtl/regfile_port_arbiter_rr_pick2.sv | 68 ++++++
 rtl/regfile_port_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : shared constants for the 16x16 register file port arbiter
// rev 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NREGS = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_port_arbiter_if : requester bus plus the two register file ports
// rev 1.0
// ---------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = regfile_pkg::DW,
    parameter int AW   = regfile_pkg::AW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_id;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;

    logic               rd1;
    logic               wn1;
    logic [AW-1:0]      reg_id1;
    logic [DW-1:0]      write_data1;
    logic [DW-1:0]      read_data1;

    logic               rd2;
    logic               wn2;
    logic [AW-1:0]      reg_id2;
    logic [DW-1:0]      write_data2;
    logic [DW-1:0]      read_data2;

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_id, req_wdata,
        input  read_data1, read_data2,
        output req_ready, rsp_valid, rsp_data,
        output rd1, wn1, reg_id1, write_data1,
        output rd2, wn2, reg_id2, write_data2
    );

    // Requesters and register file side
    modport master (
        output req_valid, req_write, req_id, req_wdata,
        output read_data1, read_data2,
        input  req_ready, rsp_valid, rsp_data,
        input  rd1, wn1, reg_id1, write_data1,
        input  rd2, wn2, reg_id2, write_data2
    );

endinterface
`default_nettype wire

// File: rtl/regfile_port_arbiter_rr_pick2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick2 : round-robin pick of up to two non-conflicting requests
// rev 1.0
// ---------------------------------------------------------------------------
module rr_pick2
    import regfile_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = regfile_pkg::AW,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]    valid,
    input  logic [NREQ-1:0]    write,
    input  logic [NREQ*AW-1:0] id,
    input  logic [PW-1:0]      ptr,
    output logic [NREQ-1:0]    gnt1,
    output logic [NREQ-1:0]    gnt2,
    output logic               found1,
    output logic               found2,
    output logic [PW-1:0]      idx1,
    output logic [PW-1:0]      idx2
);

    int            scan_pos;
    logic [PW-1:0] cand;
    logic [AW-1:0] a_id;
    logic          a_wr;
    logic          clash;

    always_comb begin
        gnt1     = '0;
        gnt2     = '0;
        found1   = 1'b0;
        found2   = 1'b0;
        idx1     = '0;
        idx2     = '0;
        a_id     = '0;
        a_wr     = OP_READ;
        clash    = 1'b0;
        scan_pos = 0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_pos = (int'(ptr) + k) % NREQ;
            cand     = PW'(scan_pos);
            if (valid[cand]) begin
                if (!found1) begin
                    found1     = 1'b1;
                    idx1       = cand;
                    gnt1[cand] = 1'b1;
                    a_id       = id[cand*AW +: AW];
                    a_wr       = write[cand];
                end else if (!found2) begin
                    // A clashing candidate stays pending; the scan moves on past it.
                    clash = (id[cand*AW +: AW] == a_id) &&
                            ((a_wr == OP_WRITE) || (write[cand] == OP_WRITE));
                    if (!clash) begin
                        found2     = 1'b1;
                        idx2       = cand;
                        gnt2[cand] = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_port_arbiter : shares the two register file ports among NREQ users
// rev 1.0
// ---------------------------------------------------------------------------
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = regfile_pkg::DW,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_port_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [NREQ-1:0]    rsp_valid_q;
    logic [NREQ-1:0]    rsp_valid_d;
    logic [NREQ*DW-1:0] rsp_data_q;
    logic [NREQ*DW-1:0] rsp_data_d;

    logic [NREQ-1:0]    gnt1;
    logic [NREQ-1:0]    gnt2;
    logic               found1;
    logic               found2;
    logic [PW-1:0]      idx1;
    logic [PW-1:0]      idx2;
    logic               wr1;
    logic               wr2;

    rr_pick2 #(
        .NREQ (NREQ),
        .AW   (AW),
        .PW   (PW)
    ) u_pick (
        .valid  (bus.req_valid),
        .write  (bus.req_write),
        .id     (bus.req_id),
        .ptr    (ptr_q),
        .gnt1   (gnt1),
        .gnt2   (gnt2),
        .found1 (found1),
        .found2 (found2),
        .idx1   (idx1),
        .idx2   (idx2)
    );

    assign wr1 = (bus.req_write[idx1] == OP_WRITE);
    assign wr2 = (bus.req_write[idx2] == OP_WRITE);

    // Reset low masks every grant so no register file write can slip through.
    assign bus.req_ready = reset ? (gnt1 | gnt2) : '0;

    always_comb begin
        bus.rd1         = 1'b0;
        bus.wn1         = 1'b0;
        bus.reg_id1     = '0;
        bus.write_data1 = '0;
        if (reset && found1) begin
            bus.reg_id1 = bus.req_id[idx1*AW +: AW];
            if (wr1) begin
                bus.wn1         = 1'b1;
                bus.write_data1 = bus.req_wdata[idx1*DW +: DW];
            end else begin
                bus.rd1 = 1'b1;
            end
        end
    end

    always_comb begin
        bus.rd2         = 1'b0;
        bus.wn2         = 1'b0;
        bus.reg_id2     = '0;
        bus.write_data2 = '0;
        if (reset && found2) begin
            bus.reg_id2 = bus.req_id[idx2*AW +: AW];
            if (wr2) begin
                bus.wn2         = 1'b1;
                bus.write_data2 = bus.req_wdata[idx2*DW +: DW];
            end else begin
                bus.rd2 = 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt1[i] && !wr1) begin
                rsp_valid_d[i]          = 1'b1;
                rsp_data_d[i*DW +: DW]  = bus.read_data1;
            end else if (gnt2[i] && !wr2) begin
                rsp_valid_d[i]          = 1'b1;
                rsp_data_d[i*DW +: DW]  = bus.read_data2;
            end
        end
    end

    // Port 2 is always later in scan order than port 1, so it sets the new start.
    always_comb begin
        ptr_d = ptr_q;
        if (found2) begin
            ptr_d = PW'(wrap_inc(32'(idx2), NREQ));
        end else if (found1) begin
            ptr_d = PW'(wrap_inc(32'(idx1), NREQ));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire
